vertex_transform: RTL

Streaming 4x4 transform stage for the graphics test path. Consumes the packed 4x4 matrix format that the matrix multiplier produces and applies it to a stream of (x,y,z,w) vertices. It computes one output component per cycle on a single 4-lane dot-product datapath. Results are handed downstream over a valid/ready handshake.

---
 rtl/vertex_transform_pkg.sv | 32 +++
 rtl/vertex_transform_dot4.sv | 30 +++
 rtl/vertex_transform.sv | 104 ++++++++++
 3 files changed

// File: rtl/vertex_transform_pkg.sv
// Shared definitions for the vertex transform stage and its neighbours.
// Holds element/output widths, the FSM state encoding, and bit-offset helpers
// for MSB-first, row-major packing of matrices and vectors.
package vertex_transform_pkg;

  localparam int EW = 8;          // matrix element / vertex component width
  localparam int N  = 4;          // matrix dimension
  localparam int OW = 2*EW + 2;   // width of a 4-term sum of EW x EW products

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    OUT  = 2'd2
  } state_t;

  // LSB position of element (r,c) in a packed N x N matrix of ew-bit entries.
  // Element (0,0) sits in the MSBs, (N-1,N-1) in the LSBs.
  function automatic int mat_lsb(input int r, input int c, input int ew);
    return ((N*N - 1) - (r*N + c)) * ew;
  endfunction

  // LSB position of an entire row r (N entries) in a packed matrix.
  function automatic int row_lsb(input int r, input int ew);
    return (N - 1 - r) * N * ew;
  endfunction

  // LSB position of component i in a packed N-vector; component 0 in the MSBs.
  function automatic int vec_lsb(input int i, input int ew);
    return (N - 1 - i) * ew;
  endfunction

endpackage

// File: rtl/vertex_transform_dot4.sv
// Combinational 4-lane dot product: sum of a[i]*b[i], zero-extended to OW bits.
// Ports: a, b = packed N-vectors (lane 0 in MSBs); sum = OW-bit unsigned result.
// No state; result is valid in the same cycle as the inputs.
module vertex_transform_dot4
  import vertex_transform_pkg::vec_lsb;
#(
  parameter int EW = 8,
  parameter int N  = 4,
  parameter int OW = 2*EW + 2
) (
  input  logic [N*EW-1:0] a,
  input  logic [N*EW-1:0] b,
  output logic [OW-1:0]   sum
);

  logic [OW-1:0] prod [N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      // Operands widened to 2*EW so the product keeps every bit before the add.
      prod[i] = {{(OW-2*EW){1'b0}},
                 ({{EW{1'b0}}, a[vec_lsb(i, EW) +: EW]} *
                  {{EW{1'b0}}, b[vec_lsb(i, EW) +: EW]})};
    end
  end

  // Balanced two-level adder tree; OW leaves two guard bits so it never wraps.
  assign sum = (prod[0] + prod[1]) + (prod[2] + prod[3]);

endmodule

// File: rtl/vertex_transform.sv
// Streaming 4x4 matrix x vertex transform, one output component per cycle.
// Ports: clk/rst_n; mat_in/mat_load/mat_ready matrix load; vin_* vertex input
// handshake; vout_* transformed-vertex output handshake (x' in MSBs).
module vertex_transform #(
  parameter int EW = vertex_transform_pkg::EW,
  parameter int N  = vertex_transform_pkg::N,
  parameter int OW = vertex_transform_pkg::OW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N*N*EW-1:0] mat_in,
  input  logic              mat_load,
  output logic              mat_ready,
  input  logic [N*EW-1:0]   vin_data,
  input  logic              vin_valid,
  output logic              vin_ready,
  output logic [N*OW-1:0]   vout_data,
  output logic              vout_valid,
  input  logic              vout_ready
);

  import vertex_transform_pkg::*;

  localparam int RW = $clog2(N);
  localparam logic [RW-1:0] LAST_ROW = RW'(N - 1);

  state_t           state, state_nxt;
  logic [RW-1:0]    row;
  logic [N*N*EW-1:0] mat_reg;
  logic [N*EW-1:0]  vtx_reg;
  logic [N*EW-1:0]  row_sel;
  logic [OW-1:0]    dot;
  logic             vin_fire;
  logic             mat_fire;

  assign vin_fire = vin_valid & vin_ready;
  assign mat_fire = (state == IDLE) & mat_load;

  // The single dot-product datapath is time-shared across rows.
  assign row_sel = mat_reg[row_lsb(int'(row), EW) +: N*EW];

  vertex_transform_dot4 #(
    .EW (EW),
    .N  (N),
    .OW (OW)
  ) u_dot4 (
    .a   (row_sel),
    .b   (vtx_reg),
    .sum (dot)
  );

  always_comb begin
    state_nxt  = state;
    mat_ready  = 1'b0;
    vin_ready  = 1'b0;
    vout_valid = 1'b0;
    case (state)
      IDLE: begin
        mat_ready = 1'b1;
        // A matrix load takes priority; the vertex waits so it sees the new matrix.
        vin_ready = ~mat_load;
        if (vin_valid && !mat_load) begin
          state_nxt = CALC;
        end
      end
      CALC: begin
        if (row == LAST_ROW) begin
          state_nxt = OUT;
        end
      end
      OUT: begin
        vout_valid = 1'b1;
        if (vout_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      row       <= '0;
      mat_reg   <= '0;
      vtx_reg   <= '0;
      vout_data <= '0;
    end else begin
      state <= state_nxt;
      if (mat_fire) begin
        mat_reg <= mat_in;
      end
      if (vin_fire) begin
        vtx_reg <= vin_data;
        row     <= '0;
      end else if (state == CALC) begin
        vout_data[vec_lsb(int'(row), OW) +: OW] <= dot;
        // Wraps back to 0 after the last row, ready for the next vertex.
        row <= row + 1'b1;
      end
    end
  end

endmodule
